multiplier_result_queue: RTL

Signed-result formatter and output queue that sits directly downstream of the integer multiplier. It accepts the multiplier's unsigned product magnitude plus sign through the multiplier's valid/ack handshake. It converts each product to a two's-complement result with a signed-overflow flag. Results are buffered in a DEPTH-entry FIFO and presented to the writeback stage with a valid/ready handshake.

---
 rtl/multiplier_result_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/multiplier_result_queue.sv
// Signed-result formatter and FIFO between the integer multiplier and writeback.
// Captures product magnitude + sign, formats to two's complement with overflow, queues results.
module multiplier_result_queue #(
    parameter int PRODUCT_WIDTH_IN_BITS = 64,
    parameter int QUEUE_DEPTH           = 2
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic                               product_valid_in,
    input  logic                               product_sign_in,
    input  logic [PRODUCT_WIDTH_IN_BITS-1:0]   product_in,
    output logic                               issue_ack_out,
    output logic                               result_valid_out,
    output logic [PRODUCT_WIDTH_IN_BITS-1:0]   result_out,
    output logic                               result_overflow_out,
    input  logic                               result_ready_in,
    output logic                               queue_full_out,
    output logic [$clog2(QUEUE_DEPTH):0]       queue_count_out
);

    localparam int W     = PRODUCT_WIDTH_IN_BITS;
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // Entry layout: {overflow, result}. Negative overflow only when magnitude exceeds 2^(W-1).
    function automatic logic [W:0] format_product(input logic sign, input logic [W-1:0] mag);
        logic [W-1:0] res;
        logic         ovf;
        if (sign) begin
            res = ~mag + W'(1'b1);
            ovf = mag[W-1] & (|mag[W-2:0]);
        end else begin
            res = mag;
            ovf = mag[W-1];
        end
        return {ovf, res};
    endfunction

    logic [W:0]       mem_r [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ack_r;
    logic             valid_r;
    logic             full_r;
    logic             capture_s;
    logic             pop_s;

    assign capture_s = product_valid_in & ~ack_r & ~full_r;
    assign pop_s     = valid_r & result_ready_in;

    // Occupancy update from capture/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({capture_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count, handshake and status registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            ack_r   <= capture_s;
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            full_r  <= (count_nxt_s == DEPTH_C);
        end
    end

    // Result storage; cleared on reset so an empty queue reads zero.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_r[i] <= {(W + 1){1'b0}};
            end
        end else if (capture_s) begin
            mem_r[wr_ptr_r] <= format_product(product_sign_in, product_in);
        end
    end

    assign issue_ack_out       = ack_r;
    assign result_valid_out    = valid_r;
    assign queue_full_out      = full_r;
    assign queue_count_out     = count_r;
    assign result_out          = mem_r[rd_ptr_r][W-1:0];
    assign result_overflow_out = mem_r[rd_ptr_r][W];

endmodule
